// File: rtl/timer_counter.sv
// timer_counter
// Prescaled 64-bit free-running count engine. Takes enable, divider, halt
// and direct-write controls from the register block and produces the live
// count, a one-cycle increment pulse and the debug halt acknowledge.
module timer_counter (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        halt_req,
  input  logic        dbg_mode,
  input  logic        counter_clear,
  input  logic [1:0]  counter_write_sel,
  input  logic [31:0] counter_write_data,
  output logic [63:0] cnt_val,
  output logic        halt_ack_status,
  output logic        cnt_tick
);

  logic [7:0] int_cnt;
  logic [3:0] eff_exp;
  logic [8:0] limit_full;
  logic [7:0] limit;
  logic       write_any;
  logic       tick;

  // Saturate the divider exponent at 8 (divide-by-256 max), build the
  // prescaler terminal value and decide whether this edge increments.
  always_comb begin
    eff_exp    = (div_val > 4'd8) ? 4'd8 : div_val;
    limit_full = (9'd1 << eff_exp) - 9'd1;
    limit      = limit_full[7:0];
    write_any  = |counter_write_sel;
    tick       = timer_en && !halt_ack_status &&
                 (!div_en || (eff_exp == 4'd0) || (int_cnt == limit));
  end

  // Prescaler: reset whenever counting is off or the counter is cleared,
  // frozen while halted so the phase survives a debug halt.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      int_cnt <= 8'd0;
    end else if (!timer_en || !div_en || counter_clear) begin
      int_cnt <= 8'd0;
    end else if (halt_ack_status) begin
      int_cnt <= int_cnt;
    end else if (tick) begin
      int_cnt <= 8'd0;
    end else begin
      int_cnt <= int_cnt + 8'd1;
    end
  end

  // Main counter: clear beats direct writes, writes beat the increment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_val <= 64'd0;
    end else if (counter_clear) begin
      cnt_val <= 64'd0;
    end else if (write_any) begin
      cnt_val[31:0]  <= counter_write_sel[0] ? counter_write_data : cnt_val[31:0];
      cnt_val[63:32] <= counter_write_sel[1] ? counter_write_data : cnt_val[63:32];
    end else if (tick) begin
      cnt_val <= cnt_val + 64'd1;
    end
  end

  // Registered status: halt only acknowledged in debug mode, and the tick
  // pulse is suppressed when a clear or write overrode the increment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      halt_ack_status <= 1'b0;
      cnt_tick        <= 1'b0;
    end else begin
      halt_ack_status <= halt_req && dbg_mode;
      cnt_tick        <= tick && !counter_clear && !write_any;
    end
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Prescaled 64-bit free-running count engine of the timer, directly downstream of the register block. It consumes the register block's control and command outputs (enable, divider, halt request, clear, direct counter writes). It produces the live count `cnt_val`, which feeds the register block read path and the interrupt comparator, and the halt acknowledge status. All state is held in flops clocked by `sys_clk`.

## Interface
Parameters: none (widths fixed by the register map).

Ports:
- sys_clk  input  1  system clock; reset sys_rst_n, asynchronous, active-low; clock sys_clk
- sys_rst_n  input  1  asynchronous active-low reset
- timer_en  input  1  count enable (TCR[0])
- div_en  input  1  prescaler enable (TCR[1])
- div_val  input  4  prescaler exponent, divide by 2^div_val (TCR[11:8])
- halt_req  input  1  debug halt request (THCSR[0])
- dbg_mode  input  1  debug mode indicator from the system; halt only honoured when 1
- counter_clear  input  1  one-cycle pulse, zero the counter
- counter_write_sel  input  2  bit0 loads cnt[31:0], bit1 loads cnt[63:32]
- counter_write_data  input  32  data for direct counter writes
- cnt_val  output  64  registered counter value
- halt_ack_status  output  1  registered halt acknowledge (THCSR[1])
- cnt_tick  output  1  registered pulse, high for one cycle after every increment

## Operation
- Prescaler `int_cnt`, 8 bits. Effective exponent `e` = div_val, saturated to 8 when div_val > 8. Limit = 2^e − 1.
- Tick condition (combinational): timer_en && !halt_ack_status && (!div_en || e==0 || int_cnt==limit).
- int_cnt next-state, in priority order:
  - cleared when !timer_en || !div_en || counter_clear;
  - held when halt_ack_status;
  - set to 0 on tick;
  - otherwise incremented.
- Counter next-state, in priority order:
  - counter_clear → 64'h0;
  - any counter_write_sel bit set → selected half(s) take counter_write_data; the unselected half holds; no increment that cycle;
  - tick → cnt_val + 1, full 64-bit carry; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0;
  - otherwise hold.
- Writes and clear are honoured regardless of timer_en or halt. A direct write does not disturb int_cnt.
- Both write_sel bits set in one cycle: both halves load the same 32-bit data.
- Halt: halt_ack_status <= halt_req && dbg_mode every cycle. While halt_ack_status=1, counter and prescaler are frozen. halt_req with dbg_mode=0 has no effect and is never acknowledged.
- cnt_tick <= tick condition, gated off when a clear or write wins that cycle.
- div_en and div_val are write-protected while timer_en=1 (enforced upstream). The block does not need to handle a divider change mid-count beyond the rules above.
- timer_en falling: counting stops immediately. The counter value is held until the counter_clear pulse arrives one cycle later. int_cnt clears.

## Timing
- Reset values: cnt_val=0, halt_ack_status=0, cnt_tick=0, int_cnt=0.
- Latency, div_en=0: timer_en sampled high at edge E0 → cnt_val=1 after E0, then +1 every edge.
- Latency, div_en=1, div_val=N: first increment after the 2^N-th edge at which timer_en=1. Thereafter one increment every 2^N edges.
- Counter write: new value visible on cnt_val the edge after counter_write_sel is sampled high.
- Halt entry: halt_req&&dbg_mode sampled at edge H. halt_ack_status=1 after H. A tick evaluated at H still increments. No tick occurs at any later edge while the acknowledge is high.
- Halt release: halt_ack_status falls one edge after the request drops. Counting resumes at the following edge, with the prescaler phase preserved.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous). Counting restarts from 0 at the first edge after deassertion with timer_en=1.

## Test plan
- Reset, then timer_en=1, div_en=0 for 10 cycles → cnt_val=10; cnt_tick high on every one of those cycles.
- div_en=1, div_val=2, timer_en=1 for 12 cycles → cnt_val=3; increments occur only on every 4th edge. Repeat with div_val=4'hF → behaves as divide-by-256.
- Write counter_write_sel=2'b11, data 32'hFFFF_FFFF; then write_sel=2'b01 with 32'hFFFF_FFFE; count 2 cycles undivided → cnt_val goes ...FFFF_FFFF then 64'h0 (wrap).
- Running, with simultaneous counter_clear and counter_write_sel=2'b01 → cnt_val=0 (clear wins). Write to bit1 while a tick is due → low half unchanged, no increment.
- Running at cnt_val=5 undivided; halt_req=1, dbg_mode=1 → cnt_val freezes at 6 and halt_ack_status=1 one edge later. Drop halt_req → ack clears, then counting resumes at 7. Repeat with dbg_mode=0 → no freeze, ack stays 0.
- Assert sys_rst_n low mid-count with div_val=3 → all outputs 0 immediately. After release, the first increment occurs after 8 enabled edges.
